// File: rtl/sram_bus_arbiter.sv
// Merges the instruction-fetch and data SRAM-like channels onto one master port.
// An in-order ID FIFO routes each m_data_ok back to the master that issued it.
module sram_bus_arbiter #(
   parameter int OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [2:0]  data_size,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        m_req,
   output logic        m_wr,
   output logic [3:0]  m_wstrb,
   output logic [31:0] m_addr,
   output logic [2:0]  m_size,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok
);

   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = PW + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   logic [1:0]             state_q, state_d;
   logic                   lastInst_q, lastInst_d;
   logic [OUTSTANDING-1:0] idFifo_q;
   logic [PW-1:0]          rdPtr_q, wrPtr_q;
   logic [CW-1:0]          count_q, count_d;

   logic selData, reqActive, grantValid, fifoFull, push, pop, headData;

   // Pick the master: fixed by the lock in GNT_x, otherwise alternate on ties.
   always_comb begin
      selData   = 1'b0;
      reqActive = 1'b0;
      case (state_q)
         GNT_I: begin
            selData   = 1'b0;
            reqActive = inst_req;
         end
         GNT_D: begin
            selData   = 1'b1;
            reqActive = data_req;
         end
         default: begin
            selData   = (inst_req && data_req) ? lastInst_q : data_req;
            reqActive = inst_req | data_req;
         end
      endcase
   end

   assign grantValid = reqActive & resetn;
   assign fifoFull   = (count_q == CW'(OUTSTANDING));
   assign m_req      = grantValid & ~fifoFull;
   assign push       = m_req & m_addr_ok;
   assign pop        = m_data_ok & (count_q != '0);
   assign headData   = idFifo_q[rdPtr_q];

   assign inst_addr_ok = push & ~selData;
   assign data_addr_ok = push & selData;
   assign inst_data_ok = pop & ~headData;
   assign data_data_ok = pop & headData;
   assign inst_rdata   = m_rdata;
   assign data_rdata   = m_rdata;

   // Fields stay valid while a request is held even if a full FIFO suppresses m_req.
   always_comb begin
      m_wr    = 1'b0;
      m_wstrb = 4'h0;
      m_addr  = 32'h0;
      m_size  = 3'd0;
      m_wdata = 32'h0;
      if (grantValid) begin
         if (selData) begin
            m_wr    = data_wr;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_size  = data_size;
            m_wdata = data_wdata;
         end else begin
            m_addr  = inst_addr;
            m_size  = 3'd2;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lastInst_d = push ? ~selData : lastInst_q;
      count_d    = count_q;
      case (state_q)
         IDLE:    if (m_req && !m_addr_ok) state_d = selData ? GNT_D : GNT_I;
         GNT_I:   if (!inst_req || push) state_d = IDLE;
         GNT_D:   if (!data_req || push) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Reset starts with "inst granted last" so data wins the first tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         lastInst_q <= 1'b1;
         idFifo_q   <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         lastInst_q <= lastInst_d;
         count_q    <= count_d;
         if (push) begin
            idFifo_q[wrPtr_q] <= selData;
            wrPtr_q           <= wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
      end
   end

endmodule
